// File: rtl/sevenseg_scan.sv
// Time-multiplexed seven-segment scanner: double-buffered ASCII frame, decimal points, PWM dimming.
// Optional per-digit blinking is built when SSEG_BLINK_EN is defined.
module sevenseg_scan #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 32768,
  parameter int unsigned DIM_BITS   = 4,
  parameter int unsigned BLINK_DIV  = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] char_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blink_in,
  input  logic                    load,
  input  logic [DIM_BITS-1:0]     brightness,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   an
);

  localparam int unsigned PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  // Low seven cathode bits (active-low, gfedcba) for an ASCII code.
  function automatic logic [6:0] font7(input logic [7:0] ch);
    logic [6:0] f;
    case (ch)
      8'h20:        f = 7'h7F;
      8'h2D:        f = 7'h3F;
      8'h5F:        f = 7'h77;
      8'h30:        f = 7'h40;
      8'h31:        f = 7'h79;
      8'h32:        f = 7'h24;
      8'h33:        f = 7'h30;
      8'h34:        f = 7'h19;
      8'h35:        f = 7'h12;
      8'h36:        f = 7'h02;
      8'h37:        f = 7'h78;
      8'h38:        f = 7'h00;
      8'h39:        f = 7'h10;
      8'h41, 8'h61: f = 7'h08;
      8'h42, 8'h62: f = 7'h03;
      8'h43, 8'h63: f = 7'h46;
      8'h44, 8'h64: f = 7'h21;
      8'h45, 8'h65: f = 7'h06;
      8'h46, 8'h66: f = 7'h0E;
      8'h47:        f = 7'h02;
      8'h48:        f = 7'h09;
      8'h4B:        f = 7'h0F;
      8'h4C:        f = 7'h47;
      8'h50:        f = 7'h0C;
      8'h53:        f = 7'h12;
      8'h6F:        f = 7'h23;
      default:      f = 7'h7E;
    endcase
    return f;
  endfunction

  logic [PRE_W-1:0]        pre_q, pre_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIM_BITS-1:0]     pwm_q;
  logic                    pending_q, pending_d;
  logic [8*NUM_DIGITS-1:0] chars_q;
  logic [NUM_DIGITS-1:0]   dp_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    load_ack_q, frame_start_q;
  logic                    tick_c, boundary_c, capture_c, pwm_on_c, blank_c;

  // Scan sequencing and load handshake.
  always_comb begin
    tick_c     = (pre_q == PRE_LAST);
    boundary_c = tick_c && (idx_q == IDX_LAST);
    capture_c  = boundary_c && (pending_q || load);
    pre_d      = tick_c ? '0 : pre_q + PRE_W'(1);
    idx_d      = idx_q;
    if (tick_c) begin
      idx_d = boundary_c ? '0 : idx_q + IDX_W'(1);
    end
    pending_d  = capture_c ? 1'b0 : (pending_q || load);
  end

  // Next anode/cathode pattern from the current slot; brightness is used live.
  always_comb begin
    pwm_on_c = (brightness == '1) || (pwm_q < brightness);
    an_d     = '1;
    if (pwm_on_c && !blank_c) begin
      an_d[idx_q] = 1'b0;
    end
    seg_d    = {~dp_q[idx_q], font7(chars_q[8*idx_q +: 8])};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q         <= '0;
      idx_q         <= '0;
      pwm_q         <= '0;
      pending_q     <= 1'b0;
      chars_q       <= {NUM_DIGITS{8'h20}};
      dp_q          <= '0;
      an_q          <= '1;
      seg_q         <= 8'hFF;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      idx_q         <= idx_d;
      pwm_q         <= pwm_q + DIM_BITS'(1);
      pending_q     <= pending_d;
      if (capture_c) begin
        chars_q <= char_in;
        dp_q    <= dp_in;
      end
      an_q          <= an_d;
      seg_q         <= seg_d;
      load_ack_q    <= capture_c;
      frame_start_q <= boundary_c;
    end
  end

`ifdef SSEG_BLINK_EN
  localparam int unsigned FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_DIV - 1);

  logic [NUM_DIGITS-1:0] blink_q;
  logic [FRM_W-1:0]      frame_q;
  logic                  phase_q;

  // Frame counter and blink phase; blink mask rides along with the shadow frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_q <= '0;
      frame_q <= '0;
      phase_q <= 1'b0;
    end else begin
      if (capture_c) begin
        blink_q <= blink_in;
      end
      if (boundary_c) begin
        if (frame_q == FRM_LAST) begin
          frame_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + FRM_W'(1);
        end
      end
    end
  end

  assign blank_c = blink_q[idx_q] & phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^{blink_in, BLINK_DIV != 0};
  assign blank_c      = 1'b0;
`endif

  assign an          = an_q;
  assign seg         = seg_q;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan: reset/empty scan, table of frame loads, blink, ack-cycle reload, reset abort.
module tb_sevenseg_scan;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned DB = 2;
  localparam int unsigned BD = 2;
  localparam int SLOT  = SD;
  localparam int FRAME = SD * ND;
`ifdef SSEG_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] chars;
    logic [3:0]  dp;
    logic [3:0]  blink;
    logic [1:0]  br;
    logic [31:0] segs;  // expected seg per digit, digit 0 in the low byte
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] char_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blink_in = '0;
  logic        load = 1'b0;
  logic [1:0]  brightness = 2'd3;
  logic        load_ack, frame_start;
  logic [7:0]  seg;
  logic [3:0]  an;

  int cyc = 0;
  int total = 0;
  int passed = 0;
  vec_t vecs[6];

  sevenseg_scan #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .DIM_BITS(DB), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .char_in(char_in), .dp_in(dp_in), .blink_in(blink_in),
    .load(load), .brightness(brightness), .load_ack(load_ack),
    .frame_start(frame_start), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  // Cycle index since the last cycle in which rst was sampled high.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    else passed++;
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_an"}, 32'(an), 32'hF);
    chk({name, "_seg"}, 32'(seg), 32'hFF);
    chk({name, "_ack"}, 32'(load_ack), 32'h0);
    chk({name, "_fs"}, 32'(frame_start), 32'h0);
  endtask

  // Advance one cycle and compare all outputs against the slot/PWM/blink model.
  task automatic step_check(input logic [31:0] segs, input logic [1:0] br, input logic [3:0] bmask,
                            input logic exp_ack, input string name);
    int c, d, k, m;
    logic [3:0] ea;
    logic [7:0] es;
    logic blank;
    tick();
    c = cyc;
    ea = 4'hF;
    es = 8'hFF;
    if (c != 0) begin
      d = ((c - 1) / SLOT) % ND;
      k = (c - 1) % SLOT;
      m = (c - 1) / FRAME;
      blank = BLINK_ON && bmask[d] && (((m / BD) % 2) == 1);
      if ((br == 2'd3 || k < int'(br)) && !blank) ea[d] = 1'b0;
      es = segs[8*d +: 8];
    end
    chk({name, "_an"}, 32'(an), 32'(ea));
    chk({name, "_seg"}, 32'(seg), 32'(es));
    chk({name, "_fs"}, 32'(frame_start), 32'((c != 0) && (c % FRAME == 0)));
    chk({name, "_ack"}, 32'(load_ack), 32'(exp_ack));
  endtask

  // Bounded wait for load_ack, which must coincide with a frame start.
  task automatic wait_ack(input string name);
    int n = 0;
    while (load_ack !== 1'b1 && n < 3 * FRAME) begin
      tick();
      n++;
    end
    chk({name, "_ack_seen"}, 32'(load_ack), 32'h1);
    chk({name, "_ack_fs"}, 32'(frame_start), 32'h1);
    chk({name, "_ack_slot"}, 32'(cyc % FRAME), 32'h0);
  endtask

  initial begin
    vecs[0] = '{chars: 32'h42413231, dp: 4'b0010, blink: 4'b0000, br: 2'd3, segs: 32'h838824F9};
    vecs[1] = '{chars: 32'h5F2D617E, dp: 4'b0000, blink: 4'b0000, br: 2'd3, segs: 32'hF7BF88FE};
    vecs[2] = '{chars: 32'h202D3930, dp: 4'b1001, blink: 4'b0000, br: 2'd1, segs: 32'h7FBF9040};
    vecs[3] = '{chars: 32'h6F4C4548, dp: 4'b0000, blink: 4'b0000, br: 2'd0, segs: 32'hA3C78689};
    vecs[4] = '{chars: 32'h53504B47, dp: 4'b0100, blink: 4'b0000, br: 2'd2, segs: 32'h920C8F82};
    vecs[5] = '{chars: 32'h66656463, dp: 4'b0000, blink: 4'b0001, br: 2'd3, segs: 32'h8E86A1C6};

    // Reset held three cycles, then two empty frames of spaces.
    repeat (3) begin
      tick();
      chk_reset_vals("rst_hold");
    end
    rst = 1'b0;
    chk_reset_vals("rst_rel");
    repeat (2 * FRAME) step_check(32'hFFFFFFFF, 2'd3, 4'b0000, 1'b0, "empty");

    // Table: load a frame at varying positions, then check the displayed frame.
    for (int i = 0; i < 6; i++) begin
      repeat (i + 5) tick();
      char_in    = vecs[i].chars;
      dp_in      = vecs[i].dp;
      blink_in   = vecs[i].blink;
      brightness = vecs[i].br;
      load       = 1'b1;
      tick();
      load = 1'b0;
      wait_ack($sformatf("v%0d", i));
      char_in = '0;
      dp_in   = '1;
      for (int j = 0; j < FRAME; j++)
        step_check(vecs[i].segs, vecs[i].br, vecs[i].blink, 1'b0, $sformatf("v%0d", i));
    end

    // Blink (or steady display without blink support) over both phases.
    repeat (4 * FRAME) step_check(vecs[5].segs, 2'd3, vecs[5].blink, 1'b0, "blink");

    // A load raised in the ack cycle starts a new request for the following frame.
    char_in = vecs[0].chars; dp_in = vecs[0].dp; blink_in = vecs[0].blink; brightness = 2'd3;
    load = 1'b1;
    tick();
    load = 1'b0;
    wait_ack("reload_a");
    char_in = vecs[1].chars; dp_in = vecs[1].dp; blink_in = vecs[1].blink;
    load = 1'b1;
    step_check(vecs[0].segs, 2'd3, vecs[0].blink, 1'b0, "reload_old");
    load = 1'b0;
    for (int j = 1; j < FRAME; j++)
      step_check(vecs[0].segs, 2'd3, vecs[0].blink, j == FRAME - 1, "reload_old");
    for (int j = 0; j < FRAME; j++)
      step_check(vecs[1].segs, 2'd3, vecs[1].blink, 1'b0, "reload_new");

    // Reset between load request and boundary aborts the load.
    begin
      int n = 0;
      while (cyc % FRAME != 4 && n < 2 * FRAME) begin
        tick();
        n++;
      end
    end
    char_in = vecs[0].chars; dp_in = vecs[0].dp; blink_in = 4'b0000;
    load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("abort_rst");
    tick();
    chk_reset_vals("abort_rst2");
    rst = 1'b0;
    chk_reset_vals("abort_rel");
    repeat (2 * FRAME) step_check(32'hFFFFFFFF, 2'd3, 4'b0000, 1'b0, "abort_scan");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
